// File: rtl/mc_alu.sv
// mc_alu: multi-cycle ALU. Single-cycle ops (aluc encoding) register s/z.
// MULT/MULTU/DIV/DIVU iterate for WIDTH cycles and write hi/lo.
// Optional build macro MC_ALU_OVF_EN adds a registered signed-overflow flag (ovf).
module mc_alu #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [3:0]       aluc,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] s,
   output logic             z,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             busy,
   output logic             done
`ifdef MC_ALU_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);
   localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_ADD   = 4'b0000;
   localparam logic [3:0] OP_AND   = 4'b0001;
   localparam logic [3:0] OP_XOR   = 4'b0010;
   localparam logic [3:0] OP_SLL   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_OR    = 4'b0101;
   localparam logic [3:0] OP_LUI   = 4'b0110;
   localparam logic [3:0] OP_SRL   = 4'b0111;
   localparam logic [3:0] OP_SRA   = 4'b1111;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] s_q, hi_q, lo_q;
   logic             z_q, busy_q, done_q;
   // Shared datapath: acc_hi = partial product high / remainder,
   // acc_lo = multiplier / dividend shifting into quotient, opnd = multiplicand / divisor.
   logic [WIDTH-1:0] acc_hi_q, acc_lo_q, opnd_q;
   logic [WIDTH-1:0] a_raw_q;
   logic [SHW-1:0]   cnt_q;
   logic             is_div_q, neg_q_q, neg_r_q, dvz_q;

   // Single-cycle result path
   logic [WIDTH-1:0] add_res, sub_res, sc_res;
   logic             is_multi;

   // Multi-cycle start conversion
   logic             sgn_op, a_neg, b_neg;
   logic [WIDTH-1:0] a_mag, b_mag;

   // Iteration and fix-up
   logic [WIDTH:0]     mul_sum, div_sh, div_tr;
   logic               div_ok;
   logic [WIDTH-1:0]   it_hi_d, it_lo_d;
   logic [2*WIDTH-1:0] prod_u, prod_f;
   logic [WIDTH-1:0]   quo_f, rem_f, hi_d, lo_d;

   assign add_res  = a + b;
   assign sub_res  = a - b;
   assign is_multi = (aluc[3:2] == 2'b10);

   // Single-cycle op decode; unlisted codes produce zero
   always_comb begin
      sc_res = '0;
      case (aluc)
         OP_ADD: sc_res = add_res;
         OP_SUB: sc_res = sub_res;
         OP_AND: sc_res = a & b;
         OP_OR:  sc_res = a | b;
         OP_XOR: sc_res = a ^ b;
         OP_LUI: sc_res = b << (WIDTH / 2);
         OP_SLL: sc_res = b << a[SHW-1:0];
         OP_SRL: sc_res = b >> a[SHW-1:0];
         OP_SRA: sc_res = $signed(b) >>> a[SHW-1:0];
         default: sc_res = '0;
      endcase
   end

`ifdef MC_ALU_OVF_EN
   logic ovf_q, sc_ovf;

   // Signed overflow: same-sign add or opposite-sign subtract flipping the sign
   always_comb begin
      sc_ovf = 1'b0;
      if (aluc == OP_ADD)
         sc_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
      else if (aluc == OP_SUB)
         sc_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
   end

   assign ovf = ovf_q;
`endif

   // Signed ops run on magnitudes; signs are reapplied at the end.
   // aluc[0] marks the signed variants (MULT 1001, DIV 1011).
   always_comb begin
      sgn_op = aluc[0];
      a_neg  = sgn_op & a[WIDTH-1];
      b_neg  = sgn_op & b[WIDTH-1];
      a_mag  = a_neg ? (~a + 1'b1) : a;
      b_mag  = b_neg ? (~b + 1'b1) : b;
   end

   // One shift-add or restoring-subtract step on the shared accumulator
   always_comb begin
      mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_tr  = div_sh - {1'b0, opnd_q};
      div_ok  = ~div_tr[WIDTH];
      if (is_div_q) begin
         it_hi_d = div_ok ? div_tr[WIDTH-1:0] : div_sh[WIDTH-1:0];
         it_lo_d = {acc_lo_q[WIDTH-2:0], div_ok};
      end else begin
         it_hi_d = mul_sum[WIDTH:1];
         it_lo_d = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      end
   end

   // Sign fix-up on the final iteration's result; divide-by-zero overrides
   always_comb begin
      prod_u = {it_hi_d, it_lo_d};
      prod_f = neg_q_q ? (~prod_u + 1'b1) : prod_u;
      quo_f  = neg_q_q ? (~it_lo_d + 1'b1) : it_lo_d;
      rem_f  = neg_r_q ? (~it_hi_d + 1'b1) : it_hi_d;
      if (!is_div_q) begin
         hi_d = prod_f[2*WIDTH-1:WIDTH];
         lo_d = prod_f[WIDTH-1:0];
      end else if (dvz_q) begin
         hi_d = a_raw_q;
         lo_d = '1;
      end else begin
         hi_d = rem_f;
         lo_d = quo_f;
      end
   end

   // Control FSM with registered outputs; reset aborts any op without a done pulse
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         s_q      <= '0;
         z_q      <= 1'b1;
         hi_q     <= '0;
         lo_q     <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         opnd_q   <= '0;
         a_raw_q  <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
         neg_q_q  <= 1'b0;
         neg_r_q  <= 1'b0;
         dvz_q    <= 1'b0;
`ifdef MC_ALU_OVF_EN
         ovf_q    <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (is_multi) begin
                     is_div_q <= aluc[1];
                     acc_hi_q <= '0;
                     acc_lo_q <= a_mag;
                     opnd_q   <= b_mag;
                     a_raw_q  <= a;
                     neg_q_q  <= a_neg ^ b_neg;
                     neg_r_q  <= a_neg;
                     dvz_q    <= (b == '0);
                     cnt_q    <= '0;
                     busy_q   <= 1'b1;
                     state_q  <= RUN;
                  end else begin
                     s_q    <= sc_res;
                     z_q    <= (sc_res == '0);
                     done_q <= 1'b1;
`ifdef MC_ALU_OVF_EN
                     ovf_q  <= sc_ovf;
`endif
                  end
               end
            end
            RUN: begin
               acc_hi_q <= it_hi_d;
               acc_lo_q <= it_lo_d;
               cnt_q    <= cnt_q + CNT_ONE;
               if (cnt_q == CNT_LAST) begin
                  hi_q    <= hi_d;
                  lo_q    <= lo_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign s    = s_q;
   assign z    = z_q;
   assign hi   = hi_q;
   assign lo   = lo_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_mc_alu.sv
// tb_mc_alu: scoreboard bench for mc_alu (WIDTH=32). Expected results are
// queued at issue time and compared whenever done pulses.
module tb_mc_alu;
   localparam int W = 32;

   logic         clock, reset, start;
   logic [3:0]   aluc;
   logic [W-1:0] a, b, s, hi, lo;
   logic         z, busy, done;
`ifdef MC_ALU_OVF_EN
   logic         ovf;
`endif

   mc_alu #(.WIDTH(W)) dut (
      .clock(clock), .reset(reset), .start(start), .aluc(aluc), .a(a), .b(b),
      .s(s), .z(z), .hi(hi), .lo(lo), .busy(busy), .done(done)
`ifdef MC_ALU_OVF_EN
      , .ovf(ovf)
`endif
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      logic         multi;
      logic [W-1:0] s;
      logic         z;
      logic         ovf;
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      string        tag;
   } exp_t;

   exp_t         sb[$];
   exp_t         mon_e;
   int           checks = 0;
   int           failures = 0;
   logic [W-1:0] last_s = '0, last_hi = '0, last_lo = '0;
   logic         last_z = 1'b1, last_ovf = 1'b0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference for single-cycle ops, overflow from wide signed arithmetic
   function automatic exp_t sc_model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                                     input string tag);
      exp_t   e;
      longint r;
      logic [4:0] sh;
      sh      = x[4:0];
      e.multi = 1'b0;
      e.tag   = tag;
      e.hi    = '0;
      e.lo    = '0;
      e.ovf   = 1'b0;
      case (op)
         4'b0000: begin e.s = x + y; r = longint'($signed(x)) + longint'($signed(y)); end
         4'b0100: begin e.s = x - y; r = longint'($signed(x)) - longint'($signed(y)); end
         4'b0001: begin e.s = x & y; r = 0; end
         4'b0101: begin e.s = x | y; r = 0; end
         4'b0010: begin e.s = x ^ y; r = 0; end
         4'b0110: begin e.s = {y[15:0], 16'h0000}; r = 0; end
         4'b0011: begin e.s = y << sh; r = 0; end
         4'b0111: begin e.s = y >> sh; r = 0; end
         4'b1111: begin e.s = W'($signed(y) >>> sh); r = 0; end
         default: begin e.s = '0; r = 0; end
      endcase
      if (op == 4'b0000 || op == 4'b0100)
         e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      e.z = (e.s == '0);
      return e;
   endfunction

   // Reference for multi-cycle ops, returns {hi, lo}
   function automatic logic [63:0] mc_model(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      logic [63:0] ux, uy, r;
      longint      p, q, rm;
      ux = {32'h0, x};
      uy = {32'h0, y};
      r  = '0;
      case (op)
         4'b1000: r = ux * uy;
         4'b1001: begin p = longint'($signed(x)) * longint'($signed(y)); r = p; end
         4'b1010: r = (y == 0) ? {x, 32'hFFFFFFFF} : {x % y, x / y};
         default: begin
            if (y == 0) r = {x, 32'hFFFFFFFF};
            else begin
               q  = longint'($signed(x)) / longint'($signed(y));
               rm = longint'($signed(x)) % longint'($signed(y));
               r  = {rm[31:0], q[31:0]};
            end
         end
      endcase
      return r;
   endfunction

   // Compare outputs against the oldest queued expectation on each done pulse
   always @(negedge clock) begin
      if (done === 1'b1) begin
         if (sb.size() == 0) chk("spurious_done", 1, 0);
         else begin
            mon_e = sb.pop_front();
            if (!mon_e.multi) begin
               chk({mon_e.tag, "_s"}, s, mon_e.s);
               chk({mon_e.tag, "_z"}, z, mon_e.z);
               chk({mon_e.tag, "_busy"}, busy, 0);
               chk({mon_e.tag, "_hi_hold"}, hi, last_hi);
`ifdef MC_ALU_OVF_EN
               chk({mon_e.tag, "_ovf"}, ovf, mon_e.ovf);
               last_ovf = mon_e.ovf;
`endif
               last_s = mon_e.s;
               last_z = mon_e.z;
            end else begin
               chk({mon_e.tag, "_hi"}, hi, mon_e.hi);
               chk({mon_e.tag, "_lo"}, lo, mon_e.lo);
               chk({mon_e.tag, "_s_hold"}, s, last_s);
               chk({mon_e.tag, "_z_hold"}, z, last_z);
`ifdef MC_ALU_OVF_EN
               chk({mon_e.tag, "_ovf_hold"}, ovf, last_ovf);
`endif
               last_hi = mon_e.hi;
               last_lo = mon_e.lo;
            end
         end
      end
   end

   // Drive one start cycle; called and returns on a falling edge
   task automatic issue(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
      start = 1'b1;
      aluc  = op;
      a     = x;
      b     = y;
      @(negedge clock);
   endtask

   task automatic single(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y, input string tag);
      sb.push_back(sc_model(op, x, y, tag));
      issue(op, x, y);
   endtask

   // Multi-cycle op: operands scrambled after the start edge, optional ignored start mid-run
   task automatic run_multi(input logic [3:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic [63:0] exp_hl, input bit poke, input string tag);
      exp_t e;
      int   n, nb;
      e.multi = 1'b1;
      e.s = '0; e.z = 1'b0; e.ovf = 1'b0;
      e.hi = exp_hl[63:32];
      e.lo = exp_hl[31:0];
      e.tag = tag;
      sb.push_back(e);
      issue(op, x, y);
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      n = 1;
      nb = 0;
      while (done !== 1'b1 && n < 200) begin
         if (busy === 1'b1) nb++;
         if (n == 16) begin
            chk({tag, "_hi_run_hold"}, hi, last_hi);
            chk({tag, "_lo_run_hold"}, lo, last_lo);
         end
         if (poke && n == 10) begin
            start = 1'b1; aluc = 4'b0000; a = 32'h1; b = 32'h1;
         end else start = 1'b0;
         @(negedge clock);
         n++;
      end
      start = 1'b0;
      // done sampled WIDTH edges after the start edge
      chk({tag, "_latency"}, n, W + 1);
      chk({tag, "_busy_cycles"}, nb, W);
      chk({tag, "_busy_at_done"}, busy, 0);
      @(negedge clock);
      chk({tag, "_done_1cyc"}, done, 0);
   endtask

   logic [3:0] rop;
   logic [W-1:0] rx, ry;
   int nd;

   initial begin
      reset = 1'b1; start = 1'b0; aluc = '0; a = '0; b = '0;
      repeat (2) @(negedge clock);
      chk("rst_s", s, 0);
      chk("rst_z", z, 1);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
`ifdef MC_ALU_OVF_EN
      chk("rst_ovf", ovf, 0);
`endif
      reset = 1'b0;
      @(negedge clock);

      single(4'b0000, 32'h7FFFFFFF, 32'h1, "add_ovf");
      start = 1'b0;
      @(negedge clock);
      chk("add_done_1cyc", done, 0);

      single(4'b0100, 32'd5, 32'd5, "sub_zero");
      single(4'b0010, 32'hFFFF0000, 32'h0000FFFF, "xor");
      single(4'b1111, 32'h4, 32'h80000000, "sra");
      single(4'b0111, 32'h4, 32'h80000000, "srl");
      single(4'b0011, 32'h25, 32'h1, "sll");
      single(4'b0110, 32'h0, 32'h1234, "lui");
      single(4'b1100, 32'h5, 32'h6, "undef");
      single(4'b0100, 32'h80000000, 32'h1, "sub_ovf");
      single(4'b0010, 32'hFFFF0000, 32'h0000FFFF, "xor2");
      start = 1'b0;
      repeat (2) @(negedge clock);
      chk("sb_drain1", sb.size(), 0);

      run_multi(4'b1001, 32'hFFFFFFFD, 32'd7, {32'hFFFFFFFF, 32'hFFFFFFEB}, 1'b1, "mult");
      run_multi(4'b1011, 32'hFFFFFFF9, 32'd2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 1'b0, "div");
      run_multi(4'b1010, 32'd7, 32'd0, {32'h00000007, 32'hFFFFFFFF}, 1'b0, "divu_z");
      run_multi(4'b1011, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b0, "div_min");
      run_multi(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, {32'hFFFFFFFE, 32'h00000001}, 1'b0, "multu");

      for (int i = 0; i < 8; i++) begin
         rop = 4'b1000 | 4'($urandom_range(0, 3));
         rx  = $urandom;
         ry  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         run_multi(rop, rx, ry, mc_model(rop, rx, ry), 1'b0, "rnd_mc");
      end

      for (int i = 0; i < 16; i++) begin
         rop = 4'($urandom);
         if (rop[3:2] == 2'b10) rop = 4'b0000;
         single(rop, $urandom, $urandom, "rnd_sc");
      end
      start = 1'b0;
      repeat (2) @(negedge clock);
      chk("sb_drain2", sb.size(), 0);

      // Abort mid-run: no done for the dropped op, everything back to reset values
      issue(4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF);
      start = 1'b0;
      repeat (9) @(negedge clock);
      chk("abort_busy_pre", busy, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_s", s, 0);
      chk("abort_z", z, 1);
      chk("abort_done", done, 0);
      last_s = '0; last_z = 1'b1; last_hi = '0; last_lo = '0; last_ovf = 1'b0;
      nd = 0;
      repeat (40) begin
         @(negedge clock);
         if (done === 1'b1) nd++;
      end
      chk("abort_no_done", nd, 0);

      // Reset and start together: start dropped
      reset = 1'b1; start = 1'b1; aluc = 4'b0000; a = 32'd5; b = 32'd6;
      @(negedge clock);
      reset = 1'b0; start = 1'b0;
      chk("rst_start_s", s, 0);
      chk("rst_start_done", done, 0);
      @(negedge clock);
      chk("rst_start_done2", done, 0);
      chk("rst_start_z", z, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mc_alu.md
Name: mc_alu

Overview:
- Parametrised multi-cycle ALU for the next-generation single-cycle/pipelined CPU datapath.
- Retains the existing 4-bit aluc op encoding for the single-cycle ops, registers their result, and adds the iterative MULT/MULTU/DIV/DIVU ops.
- MULT/MULTU/DIV/DIVU write dedicated HI/LO registers through a start/busy/done handshake.
- The control unit stalls the pipeline while busy is high.

Parameters:
- WIDTH, 32, operand/result width; power of 2, at least 8.
- SHW, log2(WIDTH), shift-amount bits taken from a; derived, not overridden.

Ports:
- clock  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  op request; sampled on the rising edge.
- aluc  input  4  operation select.
- a  input  WIDTH  operand A (shift amount in a[SHW-1:0]).
- b  input  WIDTH  operand B.
- s  output  WIDTH  registered single-cycle result.
- z  output  1  registered, 1 when s==0.
- hi  output  WIDTH  product high half / remainder.
- lo  output  WIDTH  product low half / quotient.
- busy  output  1  multi-cycle op in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset values: s=0, z=1, hi=0, lo=0, busy=0, done=0, state IDLE.
- Opcodes, full decode with no don't-cares:
  - 0000 ADD, 0100 SUB, 0001 AND, 0101 OR, 0010 XOR.
  - 0110 LUI: s = b << (WIDTH/2).
  - 0011 SLL, 0111 SRL (logical), 1111 SRA (arithmetic); shift b by a[SHW-1:0].
  - 1000 MULTU, 1001 MULT, 1010 DIVU, 1011 DIV.
  - Other codes: s=0.
- ADD/SUB wrap modulo 2^WIDTH; no trap.
- States: IDLE, RUN.
- IDLE, start=1, single-cycle op at edge E0:
  - s and z updated at E0.
  - done=1 for exactly the following cycle; busy stays 0.
  - Back-to-back single-cycle starts are accepted every cycle.
- IDLE, start=1, multi-cycle op at E0:
  - Latch operands; signed ops convert both operands to magnitudes and record the result signs.
  - Counter cleared; busy=1; go to RUN.
- RUN, edges E1..EW:
  - One shift-add (multiply) or restoring-subtract (divide) iteration per edge; counter increments.
  - At EW: hi/lo written after sign fix-up; busy=0; done=1 for one cycle; return to IDLE.
  - busy is high for exactly WIDTH cycles; done occurs WIDTH edges after the start edge.
- s/z are unchanged by multi-cycle ops.
- hi/lo are unchanged by single-cycle ops and during RUN; they update only at EW.
- start during RUN is ignored: no queuing, and s/z are not updated.
- MULT/MULTU: {hi,lo} = full 2*WIDTH-bit product, signed or unsigned.
- DIV/DIVU: lo = quotient, truncated toward zero; hi = remainder, same sign as dividend.
- Divide by zero (b==0, either signedness): still WIDTH cycles; lo = all ones, hi = a.
- DIV of most-negative by -1: lo = most-negative, hi = 0; no flag.
- Reset in any state, including mid-RUN, at the next edge:
  - Returns to IDLE with all reset values.
  - No done pulse for the aborted op.
- reset and start asserted in the same cycle: reset wins, start is dropped.
- Operand inputs may change after E0; the multi-cycle result depends only on values latched at E0.

Optional Feature:
- Macro: MC_ALU_OVF_EN.
- Defined:
  - Adds output ovf (1 bit, reset 0), registered together with s.
  - ovf=1 when ADD or SUB produces signed two's-complement overflow; 0 for all other single-cycle ops.
  - ovf is held during multi-cycle ops.
- Undefined: port ovf is absent and no overflow logic is built; all other behaviour is identical.

Test Plan:
- ADD a=0x7FFFFFFF b=0x00000001, start 1 cycle -> next cycle s=0x80000000, z=0, done=1 for 1 cycle, busy=0; with MC_ALU_OVF_EN, ovf=1.
- SUB a=5 b=5, then XOR a=0xFFFF0000 b=0x0000FFFF on consecutive cycles -> s=0, z=1, then s=0xFFFFFFFF, z=0; two done pulses.
- SRA b=0x80000000 a=4 -> s=0xF8000000; SRL same operands -> 0x08000000; SLL b=1 a=0x25 (uses a[4:0]=5) -> 0x00000020; LUI b=0x1234 -> 0x12340000.
- MULT a=0xFFFFFFFD(-3) b=7 -> busy high 32 cycles, done 32 edges after start; hi=0xFFFFFFFF, lo=0xFFFFFFEB. A start pulse with ADD issued at cycle 10 is ignored: s unchanged.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=0x00000007. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU a=b=0xFFFFFFFF, reset asserted at RUN cycle 10 -> next cycle busy=0, hi=lo=0, s=0, z=1; no done pulse for the entire remainder of the run.
